// File: rtl/wb_register_file.sv
// Writeback stage: selects the ALU, load or link value, commits it to the GPR file and serves two decode read ports.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module wb_register_file #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  REG_COUNT  = 32,
    parameter int                  SP_INDEX   = 29,
    parameter logic [DATA_WIDTH-1:0] SP_INIT  = 32'h0000_03FC
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         WB_RegWrite,
    input  logic                         WB_MemoryToReg,
    input  logic                         WB_PCEight,
    input  logic [$clog2(REG_COUNT)-1:0] WB_WriteRegister,
    input  logic [DATA_WIDTH-1:0]        AluResult,
    input  logic [DATA_WIDTH-1:0]        DataMemoryResult,
    input  logic [DATA_WIDTH-1:0]        WB_PCAddResult,
    input  logic [$clog2(REG_COUNT)-1:0] ReadRegister1,
    input  logic [$clog2(REG_COUNT)-1:0] ReadRegister2,
    output logic [DATA_WIDTH-1:0]        ReadData1,
    output logic [DATA_WIDTH-1:0]        ReadData2,
    output logic [DATA_WIDTH-1:0]        WB_WriteData,
    output logic                         WB_WriteValid
);
    localparam int IDX_W = $clog2(REG_COUNT);

    logic [DATA_WIDTH-1:0] gpr_reg [REG_COUNT];
    logic [IDX_W-1:0]      read_index [2];

    // Link writes PC+8 of the branch, i.e. the WB instruction's PC+4 plus one more word.
    always_comb begin
        WB_WriteData = AluResult;
        if (WB_PCEight) begin
            WB_WriteData = WB_PCAddResult + DATA_WIDTH'(4);
        end else if (WB_MemoryToReg) begin
            WB_WriteData = DataMemoryResult;
        end
    end

    assign WB_WriteValid = WB_RegWrite && (WB_WriteRegister != '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                gpr_reg[i] <= (i == SP_INDEX) ? SP_INIT : '0;
            end
        end else if (WB_WriteValid) begin
            gpr_reg[WB_WriteRegister] <= WB_WriteData;
        end
    end

    assign read_index[0] = ReadRegister1;
    assign read_index[1] = ReadRegister2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : rd_port
            logic [DATA_WIDTH-1:0] data;
            always_comb begin
                data = gpr_reg[read_index[gi]];
                if (Rst || (read_index[gi] == '0)) begin
                    data = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (WB_WriteValid && (read_index[gi] == WB_WriteRegister)) begin
                    data = WB_WriteData;
`endif
                end
            end
        end
    endgenerate

    assign ReadData1 = rd_port[0].data;
    assign ReadData2 = rd_port[1].data;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed writeback cases plus random traffic against an array model.
module tb_wb_register_file;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        WB_RegWrite;
    logic        WB_MemoryToReg;
    logic        WB_PCEight;
    logic [4:0]  WB_WriteRegister;
    logic [31:0] AluResult;
    logic [31:0] DataMemoryResult;
    logic [31:0] WB_PCAddResult;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] WB_WriteData;
    logic        WB_WriteValid;

    wb_register_file dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .WB_RegWrite      (WB_RegWrite),
        .WB_MemoryToReg   (WB_MemoryToReg),
        .WB_PCEight       (WB_PCEight),
        .WB_WriteRegister (WB_WriteRegister),
        .AluResult        (AluResult),
        .DataMemoryResult (DataMemoryResult),
        .WB_PCAddResult   (WB_PCAddResult),
        .ReadRegister1    (ReadRegister1),
        .ReadRegister2    (ReadRegister2),
        .ReadData1        (ReadData1),
        .ReadData2        (ReadData2),
        .WB_WriteData     (WB_WriteData),
        .WB_WriteValid    (WB_WriteValid)
    );

    always #5 Clk = ~Clk;

    logic [31:0] model [32];
    int          total_checks  = 0;
    int          passed_checks = 0;
    int          txn           = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_wdata(input logic pc8, input logic m2r,
                                                input logic [31:0] alu, input logic [31:0] mem,
                                                input logic [31:0] pc);
        if (pc8) return pc + 32'd4;
        if (m2r) return mem;
        return alu;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic rst,
                                               input logic wvalid, input logic [4:0] wreg,
                                               input logic [31:0] wdata);
        if (rst || idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wvalid && idx == wreg) return wdata;
`endif
        return model[idx];
    endfunction

    // One clock of traffic: drive, check the combinational outputs mid-cycle, then commit in the model.
    task automatic cycle(input logic rst, input logic rw, input logic m2r, input logic pc8,
                         input logic [4:0] wreg, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2);
        logic [31:0] wd;
        logic        wv;
        Rst = rst; WB_RegWrite = rw; WB_MemoryToReg = m2r; WB_PCEight = pc8;
        WB_WriteRegister = wreg; AluResult = alu; DataMemoryResult = mem; WB_PCAddResult = pc;
        ReadRegister1 = r1; ReadRegister2 = r2;
        wd = model_wdata(pc8, m2r, alu, mem, pc);
        wv = rw && (wreg != 5'd0);
        @(negedge Clk);
        check($sformatf("txn%0d write_data", txn), WB_WriteData, wd);
        check($sformatf("txn%0d write_valid", txn), {31'h0, WB_WriteValid}, {31'h0, wv});
        check($sformatf("txn%0d read1 r%0d", txn, r1), ReadData1, model_read(r1, rst, wv, wreg, wd));
        check($sformatf("txn%0d read2 r%0d", txn, r2), ReadData2, model_read(r2, rst, wv, wreg, wd));
        $display("txn %0d rst=%0b rw=%0b wreg=%0d wdata=%h r%0d=%h r%0d=%h", txn, rst, rw, wreg,
                 WB_WriteData, r1, ReadData1, r2, ReadData2);
        @(posedge Clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'h0000_03FC : 32'h0;
        end else if (wv) begin
            model[wreg] = wd;
        end
        txn++;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset with a simultaneous write to r29: reset wins.
        cycle(1, 1, 0, 0, 5'd29, 32'h1111_1111, 32'h0, 32'h0, 5'd29, 5'd3);

        for (int i = 0; i < 16; i++)
            cycle(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(i + 16));

        // ALU select, memory select, link, link wrap, r0 protection, same-cycle hazard.
        cycle(0, 1, 0, 0, 5'd5,  32'h1234_5678, 32'h0,         32'h0,         5'd5,  5'd6);
        cycle(0, 1, 1, 0, 5'd6,  32'h0,         32'hDEAD_BEEF, 32'h0,         5'd5,  5'd6);
        cycle(0, 1, 1, 1, 5'd31, 32'h0,         32'h5555_5555, 32'h0000_0104, 5'd6,  5'd31);
        cycle(0, 1, 0, 1, 5'd8,  32'h7777_7777, 32'h0,         32'hFFFF_FFFC, 5'd31, 5'd8);
        cycle(0, 1, 0, 0, 5'd8,  32'h0000_0042, 32'h0,         32'h0,         5'd8,  5'd8);
        cycle(0, 1, 0, 1, 5'd8,  32'h7777_7777, 32'h0,         32'hFFFF_FFFC, 5'd8,  5'd31);
        cycle(0, 1, 0, 0, 5'd0,  32'hFFFF_FFFF, 32'h0,         32'h0,         5'd0,  5'd0);
        cycle(0, 0, 0, 0, 5'd0,  32'h0,         32'h0,         32'h0,         5'd0,  5'd8);
        cycle(0, 1, 0, 0, 5'd7,  32'hA5A5_A5A5, 32'h0,         32'h0,         5'd7,  5'd7);
        cycle(0, 0, 0, 0, 5'd7,  32'h0,         32'h0,         32'h0,         5'd7,  5'd7);

        // Random traffic, half of it reading the register being written.
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wreg, r1, r2;
            wreg = 5'($urandom_range(0, 31));
            r1   = ($urandom_range(0, 1) == 1) ? wreg : 5'($urandom_range(0, 31));
            r2   = 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  wreg, $urandom, $urandom, $urandom, r1, r2);
        end

        for (int i = 0; i < 16; i++)
            cycle(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0, 5'(i), 5'(i + 16));

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule
